// File: rtl/uart_tx_sender_pkg.sv
// Shared types and frame constants for the tester-link UART transmitter.
package uart_tx_sender_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    HOLD
  } uart_tx_state_e;

  localparam int         DATA_BITS = 8;
  localparam logic       START_BIT = 1'b0;
  localparam logic       STOP_BIT  = 1'b1;
  localparam logic [1:0] RSP_TAG   = 2'b00;

  function automatic logic [DATA_BITS-1:0] frame_byte(input logic [5:0] tstate);
    return {RSP_TAG, tstate};
  endfunction

endpackage

// File: rtl/uart_tx_sender_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit period.
module baud_tick #(
  parameter int DIV = 434
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_clr,
  output logic out_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (in_clr || cnt_q == LAST) cnt_d = '0;
    // Registered tick mirrors the counter so it is high exactly while cnt_q == DIV-1.
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign out_tick = tick_q;

endmodule

// File: rtl/uart_tx_sender.sv
// Frames the 6-bit tester state as one UART byte (8N1, or 8E1 with UART_TX_PARITY_EN).
module uart_tx_sender
  import uart_tx_sender_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_s_en,
  input  logic [5:0] in_data,
  output logic       out_tx,
  output logic       out_s_bs,
  output logic       out_s_rd
);

  localparam int         DIV      = CLK_FREQ / BAUD;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_tx_state_e         state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             bit_q, bit_d;
  logic                   tick;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  baud_tick #(.DIV(DIV)) u_baud (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .in_clr  (state_q == IDLE),
    .out_tick(tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (in_s_en) begin
        shift_d = frame_byte(in_data);
        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^frame_byte(in_data);
`endif
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = HOLD;
      // Wait for the control FSM to drop enable so the same state is not resent.
      HOLD:   if (!in_s_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    out_tx = STOP_BIT;
    case (state_q)
      START:  out_tx = START_BIT;
      DATA:   out_tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: out_tx = par_q;
`endif
      default: out_tx = STOP_BIT;
    endcase
  end

  assign out_s_bs = (state_q != IDLE);
  assign out_s_rd = (state_q == STOP) && tick;

endmodule

// File: tb/tb_uart_tx_sender.sv
// Self-checking bench for uart_tx_sender at DIV=8; honours UART_TX_PARITY_EN.
module tb_uart_tx_sender;

  localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_en = 1'b0;
  logic [5:0] data = '0;
  logic       tx, bs, rd;

  int checks = 0;
  int failures = 0;

  uart_tx_sender #(.CLK_FREQ(8), .BAUD(1)) dut (
    .in_clk  (clk),
    .in_rst  (rst),
    .in_s_en (s_en),
    .in_data (data),
    .out_tx  (tx),
    .out_s_bs(bs),
    .out_s_rd(rd)
  );

  always #5 clk = ~clk;

  // Expected line level for frame cycle i (1-based) from the framing rules.
  function automatic logic exp_tx(input logic [5:0] d, input int i);
    int b;
    logic [7:0] byt;
    b   = (i - 1) / DIV;
    byt = {2'b00, d};
    if (b == 0) return 1'b0;
    if (b <= 8) return byt[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^byt;
`endif
    return 1'b1;
  endfunction

  // One frame: optional enable drop / data change at given cycles, then hold.
  task automatic test_frame(input logic [5:0] d, input int drop_at, input int change_at,
                            input int hold_extra, input string name);
    int errs;
    errs = 0;
    @(posedge clk); #1;
    data = d;
    s_en = 1'b1;
    for (int i = 1; i <= FL; i++) begin
      @(posedge clk); #1;
      if (i == drop_at) s_en = 1'b0;
      if (i == change_at) data = 6'b000000;
      @(negedge clk);
      checks++;
      if (tx !== exp_tx(d, i) || bs !== 1'b1 || rd !== (i == FL)) begin
        failures++;
        errs++;
        if (errs < 4)
          $display("FAIL %s cycle %0d: tx=%b bs=%b rd=%b expected tx=%b bs=1 rd=%b",
                   name, i, tx, bs, rd, exp_tx(d, i), (i == FL));
      end
    end
    if (s_en) begin
      for (int k = 0; k < hold_extra; k++) begin
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || bs !== 1'b1 || rd !== 1'b0) begin
          failures++;
          $display("FAIL %s_hold cycle %0d: tx=%b bs=%b rd=%b expected tx=1 bs=1 rd=0",
                   name, k, tx, bs, rd);
        end
      end
      @(posedge clk); #1;
      s_en = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bs !== 1'b1 || tx !== 1'b1 || rd !== 1'b0) begin
      failures++;
      $display("FAIL %s_hold_last: bs=%b tx=%b rd=%b expected bs=1 tx=1 rd=0", name, bs, tx, rd);
    end
    @(negedge clk);
    checks++;
    if (bs !== 1'b0 || tx !== 1'b1 || rd !== 1'b0) begin
      failures++;
      $display("FAIL %s_release: bs=%b tx=%b rd=%b expected bs=0 tx=1 rd=0", name, bs, tx, rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || bs !== 1'b0 || rd !== 1'b0) begin
      failures++;
      $display("FAIL reset: tx=%b bs=%b rd=%b expected tx=1 bs=0 rd=0", tx, bs, rd);
    end
    s_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || bs !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: tx=%b bs=%b expected tx=1 bs=0", tx, bs);
    end
  endtask

  task automatic test_basic();
    test_frame(6'b101101, 0, 0, 0, "basic_2d");
    test_frame(6'b000001, 0, 0, 0, "basic_01");
  endtask

  task automatic test_hold();
    test_frame(6'b110010, 0, 0, 20, "hold20");
  endtask

  task automatic test_data_change();
    test_frame(6'b101101, 0, 4, 2, "data_change");
  endtask

  task automatic test_en_drop();
    test_frame(6'b011110, 5 * DIV + 3, 0, 0, "en_drop");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      test_frame(6'($urandom), 0, 0, int'($urandom_range(0, 3)), "random");
  endtask

  task automatic test_reset_mid();
    // Bit 3 of the data field occupies frame cycles 33..40.
    @(posedge clk); #1;
    data = 6'b101101;
    s_en = 1'b1;
    for (int i = 1; i <= 36; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    s_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || bs !== 1'b0 || rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: tx=%b bs=%b rd=%b expected tx=1 bs=0 rd=0", tx, bs, rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || bs !== 1'b0 || rd !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet cycle %0d: tx=%b bs=%b rd=%b expected tx=1 bs=0 rd=0",
                 k, tx, bs, rd);
      end
    end
    test_frame(6'b101101, 0, 0, 1, "after_reset");
  endtask

  task automatic test_back_to_back();
    test_frame(6'b111111, 0, 0, 0, "b2b_a");
    test_frame(6'b000000, 0, 0, 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_data_change();
    test_en_drop();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
